// File: rtl/stream_sink.sv
// Terminal stream consumer: FIFO-buffered beats with framing checks and a host pop port.
// Optional build macro STREAM_SINK_STATS_EN adds frame/beat counters.
module stream_sink #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  uc_d0,
  input  logic [3:0]    uc_mflags,
  output logic [1:0]    cu_sflags,
  input  logic          rd_en,
  output logic          rd_vld,
  output logic [W-1:0]  rd_d,
  output logic [2:0]    rd_flags,
  input  logic          clr_err,
  output logic          err_nofirst,
  output logic          err_nolast,
  output logic          err_ovf,
  output logic [CW-1:0] frm_cnt,
  output logic [CW-1:0] beat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    INFRM = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]  data_reg [DEPTH];
  logic [2:0]    flag_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic bsy, push, pop;
  logic beat_f, beat_l;
  logic nofirst_set, nolast_set, ovf_set;

  // Stall decodes only from registered occupancy, keeping cu_sflags input-independent.
  assign bsy       = (count_reg == FULL_CNT);
  assign cu_sflags = {1'b0, bsy};
  assign push      = uc_mflags[0] & ~bsy;
  assign ovf_set   = uc_mflags[0] & bsy;
  assign rd_vld    = (count_reg != '0);
  assign pop       = rd_en & rd_vld;
  assign beat_f    = uc_mflags[2];
  assign beat_l    = uc_mflags[1];

  assign rd_d     = data_reg[rd_ptr_reg];
  assign rd_flags = flag_reg[rd_ptr_reg];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_reg[gi] <= '0;
        flag_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == AW'(gi))) begin
        data_reg[gi] <= uc_d0;
        flag_reg[gi] <= uc_mflags[3:1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Inside a frame, a new F always restarts a frame and keeps us in INFRM, even with L set.
  always_comb begin
    state_next  = state_reg;
    nofirst_set = 1'b0;
    nolast_set  = 1'b0;
    if (push) begin
      case (state_reg)
        IDLE: begin
          if (!beat_f)     nofirst_set = 1'b1;
          else if (!beat_l) state_next = INFRM;
        end
        INFRM: begin
          if (beat_f) begin
            nolast_set = 1'b1;
            state_next = INFRM;
          end else if (beat_l) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_nofirst <= 1'b0;
      err_nolast  <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      err_nofirst <= nofirst_set | (err_nofirst & ~clr_err);
      err_nolast  <= nolast_set  | (err_nolast  & ~clr_err);
      err_ovf     <= ovf_set     | (err_ovf     & ~clr_err);
    end
  end

`ifdef STREAM_SINK_STATS_EN
  logic [CW-1:0] frm_cnt_reg, beat_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
    end else if (push) begin
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if (beat_l) frm_cnt_reg <= frm_cnt_reg + 1'b1;
    end
  end

  assign frm_cnt  = frm_cnt_reg;
  assign beat_cnt = beat_cnt_reg;
`else
  assign frm_cnt  = '0;
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// Scoreboard bench for stream_sink: stimulus predicts accepted beats into a queue,
// a negedge monitor compares head data, status and sticky errors against the model.
module tb_stream_sink;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  uc_d0;
  logic [3:0]    uc_mflags;
  logic [1:0]    cu_sflags;
  logic          rd_en;
  logic          rd_vld;
  logic [W-1:0]  rd_d;
  logic [2:0]    rd_flags;
  logic          clr_err;
  logic          err_nofirst, err_nolast, err_ovf;
  logic [CW-1:0] frm_cnt, beat_cnt;

  stream_sink #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .uc_d0(uc_d0), .uc_mflags(uc_mflags), .cu_sflags(cu_sflags),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_d(rd_d), .rd_flags(rd_flags), .clr_err(clr_err),
    .err_nofirst(err_nofirst), .err_nolast(err_nolast), .err_ovf(err_ovf),
    .frm_cnt(frm_cnt), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   f;
  } beat_t;

  beat_t         exp_q[$];
  bit            m_in_frame, m_nofirst, m_nolast, m_ovf;
  logic [CW-1:0] m_frm, m_beat;
  int            checks = 0;
  int            passes = 0;
  bit            done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_in_frame = 0; m_nofirst = 0; m_nolast = 0; m_ovf = 0;
    m_frm = '0; m_beat = '0;
  endtask

  // Called just after a posedge: drive one cycle of inputs, then commit the model.
  task automatic step(input bit v, input bit a, input bit f, input bit l,
                      input logic [W-1:0] d, input bit rde, input bit clr);
    int  occ;
    bit  acc, ovf, nf, nl;
    occ = exp_q.size();
    uc_d0     = d;
    uc_mflags = {a, f, l, v};
    rd_en     = rde;
    clr_err   = clr;
    acc = v && (occ != DEPTH);
    ovf = v && (occ == DEPTH);
    nf  = acc && !m_in_frame && !f;
    nl  = acc && m_in_frame && f;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back('{d: d, f: {a, f, l}});
      m_beat = m_beat + 1'b1;
      if (l) m_frm = m_frm + 1'b1;
      m_in_frame = m_in_frame ? (f || !l) : (f && !l);
    end
    m_nofirst = nf || (m_nofirst && !clr);
    m_nolast  = nl || (m_nolast && !clr);
    m_ovf     = ovf || (m_ovf && !clr);
  endtask

  task automatic idle(input bit rde, input bit clr);
    step(0, 0, 0, 0, '0, rde, clr);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; uc_mflags = '0; rd_en = 0; clr_err = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares DUT state to the model once per cycle, popping on host reads.
  initial begin
    logic [CW-1:0] e_frm, e_beat;
    @(negedge clk);
    while (!done) begin
`ifdef STREAM_SINK_STATS_EN
      e_frm = m_frm; e_beat = m_beat;
`else
      e_frm = '0; e_beat = '0;
`endif
      chk("rd_vld", 32'(rd_vld), 32'(exp_q.size() != 0));
      chk("cu_sflags", 32'(cu_sflags), {30'd0, 1'b0, exp_q.size() == DEPTH});
      chk("err_nofirst", 32'(err_nofirst), 32'(m_nofirst));
      chk("err_nolast", 32'(err_nolast), 32'(m_nolast));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("frm_cnt", 32'(frm_cnt), 32'(e_frm));
      chk("beat_cnt", 32'(beat_cnt), 32'(e_beat));
      if (rst) begin
        chk("rst_rd_d", 32'(rd_d), 32'd0);
        chk("rst_rd_flags", 32'(rd_flags), 32'd0);
      end else if (exp_q.size() != 0) begin
        chk("rd_d", 32'(rd_d), 32'(exp_q[0].d));
        chk("rd_flags", 32'(rd_flags), 32'(exp_q[0].f));
        if (rd_en) begin
          $display("pop d=%h flags=%b exp d=%h flags=%b", rd_d, rd_flags, exp_q[0].d, exp_q[0].f);
          void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
  end

  initial begin
    rst = 1'b1; uc_d0 = '0; uc_mflags = '0; rd_en = 0; clr_err = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Three-beat frame held in the FIFO, then drained.
    step(1, 0, 1, 0, 16'd1, 0, 0);
    step(1, 0, 0, 0, 16'd2, 0, 0);
    step(1, 0, 0, 1, 16'd3, 0, 0);
    idle(0, 0);
    repeat (3) idle(1, 0);

    // Fill to full, a fifth beat overflows, then drain in order.
    step(1, 0, 1, 0, 16'd1, 0, 0);
    step(1, 0, 0, 0, 16'd2, 0, 0);
    step(1, 0, 0, 0, 16'd3, 0, 0);
    step(1, 1, 0, 1, 16'd4, 0, 0);
    step(1, 0, 1, 0, 16'd5, 0, 0);
    idle(0, 0);
    repeat (4) idle(1, 0);
    idle(0, 1);
    idle(0, 0);

    // Framing errors: missing F in IDLE, then F,F,L.
    step(1, 0, 0, 0, 16'h0007, 1, 0);
    step(1, 0, 1, 0, 16'h0008, 1, 0);
    step(1, 0, 1, 0, 16'h0009, 1, 0);
    step(1, 0, 0, 1, 16'h000a, 1, 0);
    idle(1, 0);
    step(1, 0, 1, 1, 16'h000b, 0, 1);
    idle(1, 0);

    // Full FIFO with simultaneous pop and push: pop happens, push refused.
    for (int i = 0; i < DEPTH; i++) step(1, 0, i == 0, i == DEPTH - 1, 16'(16'h20 + i), 0, 0);
    step(1, 0, 1, 1, 16'h00ff, 1, 0);
    idle(0, 0);
    idle(0, 1);
    repeat (3) idle(1, 0);

    // Stats frames of length 5, 1, 3 with a draining host, then reset mid-frame.
    for (int i = 0; i < 5; i++) step(1, 0, i == 0, i == 4, 16'(16'h100 + i), 1, 0);
    step(1, 0, 1, 1, 16'h0200, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, i == 0, i == 2, 16'(16'h300 + i), 1, 0);
    idle(1, 0);
    step(1, 0, 1, 0, 16'h0400, 0, 0);
    step(1, 0, 0, 0, 16'h0401, 0, 0);
    pulse_reset();
    idle(0, 0);

    // Randomized traffic with phases of light and heavy host draining.
    for (int i = 0; i < 600; i++) begin
      bit v, a, f, l, rde, clr;
      v   = ($urandom_range(0, 9) < 7);
      a   = $urandom_range(0, 1) == 1;
      f   = ($urandom_range(0, 3) == 0);
      l   = ($urandom_range(0, 3) == 0);
      rde = ((i / 40) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      if (i == 300) pulse_reset();
      step(v, a, f, l, 16'($urandom), rde, clr);
    end
    repeat (DEPTH + 1) idle(1, 0);

    done = 1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
